// File: rtl/byte_stream_fifo.sv
// Single-clock byte FIFO with registered read port, occupancy level and
// sticky overflow/underflow flags for the downstream error handling.
module byte_stream_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic          AF_RST  = (AF_THRESH == 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [LW-1:0]    level_nxt;

  // Accept decisions come from the registered flags only.
  always_comb begin
    push      = wr_en && !full;
    pop       = rd_en && !empty;
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= AF_RST;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid    <= pop;
      level       <= level_nxt;
      empty       <= (level_nxt == '0);
      full        <= (level_nxt == DEPTH_L);
      almost_full <= (level_nxt >= AF_L);
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow    <= (overflow  && !clr_err) || (wr_en && !push);
      underflow   <= (underflow && !clr_err) || (rd_en && !pop);
    end
  end

endmodule

// File: tb/tb_byte_stream_fifo.sv
// Directed bench for byte_stream_fifo: a hand-computed vector table followed
// by queue-model sequences for full/empty corners and pointer wrap.
module tb_byte_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_tests = 0;
  int n_fail  = 0;

  byte_stream_fifo #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .level(level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst; int wr; int rd; int clr; int d;
    int lvl; int e; int f; int af; int rv; int rdd; int ovf; int udf;
  } vec_t;

  vec_t vt[22];

  logic [7:0] mq[$];
  logic [7:0] m_rd;
  bit         m_rv, m_ovf, m_udf;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lvl, input int e, input int f,
                         input int af, input int rv, input int rdd, input int ovf,
                         input int udf);
    chk({tag, " level"},       int'(level),       lvl);
    chk({tag, " empty"},       int'(empty),       e);
    chk({tag, " full"},        int'(full),        f);
    chk({tag, " almost_full"}, int'(almost_full), af);
    chk({tag, " rd_valid"},    int'(rd_valid),    rv);
    chk({tag, " rd_data"},     int'(rd_data),     rdd);
    chk({tag, " overflow"},    int'(overflow),    ovf);
    chk({tag, " underflow"},   int'(underflow),   udf);
  endtask

  // Queue model: pops come from contents present before this cycle's push.
  task automatic do_step(input string tag, input bit w, input logic [7:0] d,
                         input bit r, input bit c);
    bit pu, po;
    int sz;
    pu    = w && (mq.size() < 16);
    po    = r && (mq.size() > 0);
    m_ovf = (m_ovf && !c) || (w && !pu);
    m_udf = (m_udf && !c) || (r && !po);
    m_rv  = po;
    if (po) m_rd = mq.pop_front();
    if (pu) mq.push_back(d);
    rst = 1'b0; wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk); #1;
    sz = mq.size();
    chk_all(tag, sz, int'(sz == 0), int'(sz == 16), int'(sz >= 14),
            int'(m_rv), int'(m_rd), int'(m_ovf), int'(m_udf));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;

    //          rst wr rd clr  d      lvl e f af rv rdd    ovf udf
    vt[0]  = '{1, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0,     0, 0};
    vt[1]  = '{0, 1, 0, 0, 'h11,   1, 0, 0, 0, 0, 0,     0, 0};
    vt[2]  = '{0, 1, 0, 0, 'h22,   2, 0, 0, 0, 0, 0,     0, 0};
    vt[3]  = '{0, 1, 0, 0, 'h33,   3, 0, 0, 0, 0, 0,     0, 0};
    vt[4]  = '{0, 1, 0, 0, 'h44,   4, 0, 0, 0, 0, 0,     0, 0};
    vt[5]  = '{0, 0, 1, 0, 0,      3, 0, 0, 0, 1, 'h11,  0, 0};
    vt[6]  = '{0, 0, 1, 0, 0,      2, 0, 0, 0, 1, 'h22,  0, 0};
    vt[7]  = '{0, 0, 1, 0, 0,      1, 0, 0, 0, 1, 'h33,  0, 0};
    vt[8]  = '{0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 'h33,  0, 0};
    vt[9]  = '{0, 0, 1, 0, 0,      0, 1, 0, 0, 1, 'h44,  0, 0};
    vt[10] = '{0, 0, 1, 0, 0,      0, 1, 0, 0, 0, 'h44,  0, 1};
    vt[11] = '{0, 1, 1, 1, 'h55,   1, 0, 0, 0, 0, 'h44,  0, 1};
    vt[12] = '{0, 0, 0, 1, 0,      1, 0, 0, 0, 0, 'h44,  0, 0};
    vt[13] = '{0, 0, 1, 0, 0,      0, 1, 0, 0, 1, 'h55,  0, 0};
    vt[14] = '{0, 0, 1, 0, 0,      0, 1, 0, 0, 0, 'h55,  0, 1};
    vt[15] = '{0, 1, 0, 0, 'hA1,   1, 0, 0, 0, 0, 'h55,  0, 1};
    vt[16] = '{0, 1, 0, 0, 'hA2,   2, 0, 0, 0, 0, 'h55,  0, 1};
    vt[17] = '{0, 1, 0, 0, 'hA3,   3, 0, 0, 0, 0, 'h55,  0, 1};
    vt[18] = '{0, 1, 0, 0, 'hA4,   4, 0, 0, 0, 0, 'h55,  0, 1};
    vt[19] = '{0, 1, 0, 0, 'hA5,   5, 0, 0, 0, 0, 'h55,  0, 1};
    vt[20] = '{1, 0, 1, 0, 0,      0, 1, 0, 0, 0, 0,     0, 0};
    vt[21] = '{0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0,     0, 0};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      rst     = vt[i].rst[0];
      wr_en   = vt[i].wr[0];
      rd_en   = vt[i].rd[0];
      clr_err = vt[i].clr[0];
      wr_data = 8'(vt[i].d);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vt[i].lvl, vt[i].e, vt[i].f, vt[i].af,
              vt[i].rv, vt[i].rdd, vt[i].ovf, vt[i].udf);
    end

    // Table leaves the FIFO freshly reset.
    mq.delete();
    m_rd = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) do_step($sformatf("fill%0d", i), 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("full after 16 pushes", int'(full), 1);
    do_step("push17", 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("overflow after push17", int'(overflow), 1);

    // Push+pop on full: pop wins, push rejected.
    do_step("fullboth", 1'b1, 8'hEF, 1'b1, 1'b0);
    chk("fullboth level", int'(level), 15);
    chk("fullboth rd_data", int'(rd_data), 'h80);
    do_step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) do_step($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);

    // Steady-state streaming at level 8 across pointer wrap.
    for (int i = 0; i < 8; i++) do_step($sformatf("pre%0d", i), 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      do_step($sformatf("stream%0d", i), 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      chk($sformatf("stream%0d const level", i), int'(level), 8);
    end
    for (int i = 0; i < 8; i++) do_step($sformatf("post%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
    do_step("final_empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
